// File: rtl/mult_job_arbiter.sv
// Round-robin arbiter/sequencer that shares one multiply/popcount engine between two
// requesters, guards each job with a watchdog and posts results into per-requester slots.
module mult_job_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [1:0]  req_valid,
  input  logic [47:0] req_a,
  input  logic [47:0] req_b,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ack,
  output logic [63:0] rsp_w,
  output logic [11:0] rsp_ones,
  output logic [3:0]  rsp_status,
  output logic        eng_start,
  output logic [23:0] eng_a,
  output logic [23:0] eng_b,
  input  logic        eng_done,
  input  logic [31:0] eng_w,
  input  logic        eng_valid,
  input  logic [5:0]  eng_ones,
  output logic        busy,
  output logic [15:0] job_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic        last_grant;
  logic        id;
  logic        grant;
  logic        take;
  logic [1:0]  eligible;
  logic [15:0] wait_cnt;
  logic [15:0] cnt_inc;
  logic [31:0] cap_w;
  logic [5:0]  cap_ones;
  logic [1:0]  cap_status;

  // A requester whose slot is still full cannot be granted, so a slot is never overwritten.
  assign eligible = req_valid & ~rsp_valid;
  assign take     = (state == IDLE) && (eligible != 2'b00);
  assign cnt_inc  = wait_cnt + 16'd1;
  assign busy     = (state != IDLE);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    grant = 1'b0;
    case (eligible)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign req_ready = take ? (grant ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    unique case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE: begin
        eng_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (eng_done || (cnt_inc == TIMEOUT_W)) state_nxt = DELIVER;
      DELIVER: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      eng_a      <= '0;
      eng_b      <= '0;
      wait_cnt   <= '0;
      cap_w      <= '0;
      cap_ones   <= '0;
      cap_status <= '0;
      rsp_valid  <= '0;
      rsp_w      <= '0;
      rsp_ones   <= '0;
      rsp_status <= '0;
      job_count  <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= rsp_valid & ~rsp_ack;
      unique case (state)
        IDLE: begin
          if (take) begin
            id    <= grant;
            eng_a <= grant ? req_a[47:24] : req_a[23:0];
            eng_b <= grant ? req_b[47:24] : req_b[23:0];
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (eng_done) begin
            cap_w      <= eng_w;
            cap_ones   <= eng_ones;
            cap_status <= {1'b0, eng_valid};
          end else begin
            wait_cnt <= cnt_inc;
            if (cnt_inc == TIMEOUT_W) begin
              cap_w      <= '0;
              cap_ones   <= '0;
              cap_status <= 2'b10;
            end
          end
        end
        DELIVER: begin
          // The slot being written was empty at grant time, so no ack can target it now.
          rsp_valid[id] <= 1'b1;
          if (id) begin
            rsp_w[63:32]    <= cap_w;
            rsp_ones[11:6]  <= cap_ones;
            rsp_status[3:2] <= cap_status;
          end else begin
            rsp_w[31:0]     <= cap_w;
            rsp_ones[5:0]   <= cap_ones;
            rsp_status[1:0] <= cap_status;
          end
          job_count  <= job_count + 16'd1;
          last_grant <= id;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_job_arbiter.sv
// Bench for mult_job_arbiter: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a job-level reference model.
module tb_mult_job_arbiter;

  localparam int TO = 30;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [1:0]  req_valid;
  logic [47:0] req_a, req_b;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ack;
  logic [63:0] rsp_w;
  logic [11:0] rsp_ones;
  logic [3:0]  rsp_status;
  logic        eng_start;
  logic [23:0] eng_a, eng_b;
  logic        eng_done;
  logic [31:0] eng_w;
  logic        eng_valid;
  logic [5:0]  eng_ones;
  logic        busy;
  logic [15:0] job_count;

  mult_job_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_w(rsp_w), .rsp_ones(rsp_ones),
    .rsp_status(rsp_status),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done),
    .eng_w(eng_w), .eng_valid(eng_valid), .eng_ones(eng_ones),
    .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // stimulus knobs
  bit rand_req = 0, rand_rst = 0, ack_auto = 0, ack_rand = 0;
  bit eng_rand = 0, eng_ovr = 0, spurious_en = 0, preload = 0;
  int eng_delay_cfg = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [23:0] rand24();
    logic [23:0] v;
    v = 24'($urandom);
    if ($urandom_range(0, 1) == 1) v = v & 24'h000FFF;
    return v;
  endfunction

  // Engine model: answers eng_done a configurable number of cycles after eng_start
  // (0 = never), drives garbage on the result bus otherwise.
  initial begin : engine
    int cd;
    logic [23:0] oa, ob;
    logic [47:0] p;
    cd = 0; oa = '0; ob = '0;
    eng_done = 1'b0; eng_w = '0; eng_valid = 1'b0; eng_ones = '0;
    forever begin
      @(posedge clk); #1;
      eng_done  = 1'b0;
      eng_w     = $urandom;
      eng_valid = 1'($urandom);
      eng_ones  = 6'($urandom);
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          eng_done = 1'b1;
          if (eng_ovr) begin
            eng_w = 32'h1; eng_valid = 1'b0; eng_ones = 6'd1;
          end else begin
            p         = {24'd0, oa} * {24'd0, ob};
            eng_w     = p[31:0];
            eng_valid = (p[47:32] == 16'd0);
            eng_ones  = 6'($countones(p[31:0]));
          end
        end
      end else if (spurious_en && !busy && $urandom_range(0, 7) == 0) begin
        eng_done = 1'b1;
      end
      if (eng_start) begin
        cd = eng_rand ? int'($urandom_range(1, TO + 4)) : eng_delay_cfg;
        oa = eng_a; ob = eng_b;
      end
    end
  end

  // Reference model: tracks the job in flight by its age in cycles since the handshake.
  bit          m_known = 0, m_active = 0, m_decided = 0, m_last = 1, m_id = 0;
  int          m_age = 0, m_deliver = 0;
  logic [23:0] m_a = '0, m_b = '0;
  logic [31:0] m_rw = '0;
  logic [5:0]  m_ro = '0;
  logic [1:0]  m_rs = '0, m_rv = '0;
  logic [31:0] m_w[2];
  logic [5:0]  m_o[2];
  logic [1:0]  m_s[2];
  logic [15:0] m_count = '0;

  always @(negedge clk) begin : model
    logic [1:0] elig, exp_ready, nrv;
    logic g;
    if (preload && m_known) m_count = 16'hFFFF;
    elig = req_valid & ~m_rv;
    g    = (elig == 2'b10) || (elig == 2'b11 && !m_last);
    if (m_known) begin
      exp_ready = (!m_active && elig != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("eng_start", 64'(eng_start), 64'(m_active && m_age == 1));
      check("busy", 64'(busy), 64'(m_active));
      check("eng_ab", 64'({eng_a, eng_b}), 64'({m_a, m_b}));
      check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
      check("rsp_w", rsp_w, {m_w[1], m_w[0]});
      check("rsp_ones", 64'(rsp_ones), 64'({m_o[1], m_o[0]}));
      check("rsp_status", 64'(rsp_status), 64'({m_s[1], m_s[0]}));
      check("job_count", 64'(job_count), 64'(m_count));
    end
    if (!n_reset) begin
      m_known = 1; m_active = 0; m_decided = 0; m_last = 1; m_id = 0;
      m_a = '0; m_b = '0; m_rv = '0; m_count = '0;
      for (int i = 0; i < 2; i++) begin m_w[i] = '0; m_o[i] = '0; m_s[i] = '0; end
    end else if (m_known) begin
      nrv = m_rv & ~rsp_ack;
      if (m_active) begin
        if (m_decided && m_age == m_deliver) begin
          m_w[m_id] = m_rw; m_o[m_id] = m_ro; m_s[m_id] = m_rs;
          nrv[m_id] = 1'b1;
          m_count   = m_count + 16'd1;
          m_last    = m_id;
          m_active  = 0;
        end else begin
          if (!m_decided && m_age >= 2) begin
            if (eng_done) begin
              m_rw = eng_w; m_ro = eng_ones; m_rs = {1'b0, eng_valid};
              m_decided = 1; m_deliver = m_age + 1;
            end else if (m_age == TO + 1) begin
              m_rw = '0; m_ro = '0; m_rs = 2'b10;
              m_decided = 1; m_deliver = m_age + 1;
            end
          end
          m_age++;
        end
      end else if (elig != 2'b00) begin
        m_active = 1; m_decided = 0; m_age = 1; m_id = g;
        m_a = g ? req_a[47:24] : req_a[23:0];
        m_b = g ? req_b[47:24] : req_b[23:0];
      end
      m_rv = nrv;
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (rand_rst) n_reset = ($urandom_range(0, 599) != 0);
    if (ack_auto) rsp_ack = rsp_valid;
    else if (ack_rand) rsp_ack = 2'($urandom);
    if (rand_req) begin
      req_valid = 2'($urandom);
      req_a = {rand24(), rand24()};
      req_b = {rand24(), rand24()};
    end
  endtask

  task automatic wait_hs(input logic who, output int c0);
    c0 = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req_ready[who]) begin c0 = cyc; break; end
      step();
    end
    if (c0 < 0) check("handshake_expired", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(input logic who, output int cv);
    cv = -1;
    for (int i = 0; i < 200; i++) begin
      step(); #1;
      if (rsp_valid[who]) begin cv = cyc; break; end
    end
    if (cv < 0) check("rsp_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic run_job(input logic who, input logic [23:0] a, input logic [23:0] b,
                         input int dly, output int lat);
    int c0, cv;
    eng_delay_cfg = dly;
    if (who) begin req_a[47:24] = a; req_b[47:24] = b; end
    else     begin req_a[23:0]  = a; req_b[23:0]  = b; end
    req_valid[who] = 1'b1;
    wait_hs(who, c0);
    step();
    req_valid[who] = 1'b0;
    #1;
    check("eng_start_c1", 64'(eng_start), 64'd1);
    wait_rsp(who, cv);
    lat = cv - c0;
  endtask

  task automatic ack(input logic [1:0] m);
    rsp_ack = m;
    step();
    rsp_ack = 2'b00;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    step();
    n_reset = 1'b1;
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat, got;
    n_reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ack = '0;
    step();
    do_reset();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_job_count", 64'(job_count), 64'd0);

    // single job, engine answers 24 cycles after eng_start
    run_job(1'b0, 24'd3, 24'd5, 24, lat);
    check("single_latency", 64'(lat), 64'd27);
    check("single_w", 64'(rsp_w[31:0]), 64'h0000000F);
    check("single_ones", 64'(rsp_ones[5:0]), 64'd4);
    check("single_status", 64'(rsp_status[1:0]), 64'b01);
    check("single_count", 64'(job_count), 64'd1);

    // overflow on requester 1 while slot 0 remains full
    eng_ovr = 1;
    run_job(1'b1, 24'hFFFFFF, 24'hFFFFFF, 5, lat);
    eng_ovr = 0;
    check("ovf_w1", 64'(rsp_w[63:32]), 64'h1);
    check("ovf_ones1", 64'(rsp_ones[11:6]), 64'd1);
    check("ovf_status1", 64'(rsp_status[3:2]), 64'b00);
    check("ovf_slot0_kept", 64'(rsp_w[31:0]), 64'h0000000F);
    check("ovf_both_full", 64'(rsp_valid), 64'b11);

    // contention: both always valid, acks returned at once
    do_reset();
    ack_auto = 1; eng_delay_cfg = 1; req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      got = -1;
      for (int i = 0; i < 50 && got < 0; i++) begin
        #1;
        if (req_ready != 2'b00) got = int'(req_ready[1]);
        else step();
      end
      check("grant_order", 64'(got), 64'(j % 2));
      step();
      if (j == 3) req_valid = 2'b00;
    end
    repeat (12) step();
    #1;
    check("contention_count", 64'(job_count), 64'd4);
    ack_auto = 0;

    // full slot blocks its requester until acked
    do_reset();
    eng_delay_cfg = 2;
    req_a = {24'd0, 24'd6}; req_b = {24'd0, 24'd7}; req_valid = 2'b01;
    wait_hs(1'b0, got);
    wait_rsp(1'b0, got);
    for (int i = 0; i < 10; i++) begin
      check("full_blocks", 64'(req_ready), 64'd0);
      step(); #1;
    end
    rsp_ack = 2'b01;
    #1;
    check("ack_cycle_no_grant", 64'(req_ready), 64'd0);
    step();
    rsp_ack = 2'b00;
    #1;
    check("grant_after_ack", 64'(req_ready), 64'b01);
    step();
    req_valid = 2'b00;
    wait_rsp(1'b0, got);
    ack(2'b01);

    // watchdog: silent engine, then done on the last WAIT cycle, then one cycle too late
    run_job(1'b0, 24'd4, 24'd4, 0, lat);
    check("to_latency", 64'(lat), 64'(TO + 3));
    check("to_status", 64'(rsp_status[1:0]), 64'b10);
    check("to_w", 64'(rsp_w[31:0]), 64'd0);
    check("to_ones", 64'(rsp_ones[5:0]), 64'd0);
    ack(2'b01);
    run_job(1'b0, 24'd7, 24'd9, TO, lat);
    check("edge_latency", 64'(lat), 64'(TO + 3));
    check("edge_status", 64'(rsp_status[1:0]), 64'b01);
    check("edge_w", 64'(rsp_w[31:0]), 64'd63);
    check("edge_ones", 64'(rsp_ones[5:0]), 64'd6);
    ack(2'b01);
    run_job(1'b0, 24'd7, 24'd9, TO + 1, lat);
    check("late_status", 64'(rsp_status[1:0]), 64'b10);
    ack(2'b01);

    // reset in the middle of WAIT, engine answers afterwards
    eng_delay_cfg = 20;
    req_a = {24'd0, 24'd2}; req_b = {24'd0, 24'd2}; req_valid = 2'b01;
    wait_hs(1'b0, got);
    step();
    req_valid = 2'b00;
    repeat (5) step();
    do_reset();
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_count", 64'(job_count), 64'd0);
    check("mid_rst_eng_a", 64'(eng_a), 64'd0);
    check("mid_rst_status", 64'(rsp_status), 64'd0);
    repeat (25) step();
    #1;
    check("late_done_valid", 64'(rsp_valid), 64'd0);
    check("late_done_count", 64'(job_count), 64'd0);

    // job counter wraps
    force dut.job_count = 16'hFFFF;
    preload = 1;
    #1;
    release dut.job_count;
    step();
    preload = 0;
    run_job(1'b0, 24'd10, 24'd10, 3, lat);
    check("wrap_count", 64'(job_count), 64'd0);
    check("wrap_w", 64'(rsp_w[31:0]), 64'd100);
    ack(2'b01);

    // random traffic
    rand_req = 1; ack_rand = 1; eng_rand = 1; spurious_en = 1; rand_rst = 1;
    repeat (3000) step();
    rand_req = 0; ack_rand = 0; eng_rand = 0; spurious_en = 0; rand_rst = 0;
    n_reset = 1'b1; req_valid = 2'b00; rsp_ack = 2'b11;
    repeat (TO + 10) step();
    rsp_ack = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_job_arbiter.md
# mult_job_arbiter

Arbiter and sequencer that shares one 24x24 shift-add multiply/popcount engine between two requesters. Each requester submits an operand pair over a valid/ready handshake. The block grants round-robin, issues a start pulse to the engine, and waits for its done pulse or a watchdog timeout. It then posts the product, overflow flag and one-count into a per-requester result slot, which the requester acknowledges. It sits between the bus-side register front ends and the shared multiply datapath, and exports a wrapping job counter for the GPIO output.

## Interface
Parameters:
- TIMEOUT, 255: maximum WAIT cycles before a job is aborted; legal range 1..65535.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- n_reset  in  1  reset, synchronous and active-low
- req_valid  in  2  bit i: requester i presents an operand pair
- req_a  in  48  bits [24i+23:24i]: operand A of requester i
- req_b  in  48  bits [24i+23:24i]: operand B of requester i
- req_ready  out  2  bit i: requester i's pair is taken this cycle; at most one bit high
- rsp_valid  out  2  bit i: result slot i is full
- rsp_ack  in  2  bit i: requester i consumes slot i
- rsp_w  out  64  bits [32i+31:32i]: product bits [31:0]
- rsp_ones  out  12  bits [6i+5:6i]: number of ones in rsp_w slice (0..32)
- rsp_status  out  4  bits [2i+1:2i]: {timeout, valid}; valid=1 means product fits in 32 bits
- eng_start  out  1  one-cycle engine start pulse
- eng_a, eng_b  out  24 each  operands held stable from ISSUE through WAIT
- eng_done  in  1  engine completion pulse
- eng_w  in  32  engine product low word
- eng_valid  in  1  engine no-overflow flag
- eng_ones  in  6  engine popcount of eng_w
- busy  out  1  high whenever the state is not IDLE
- job_count  out  16  completed jobs (timeouts included); wraps 0xFFFF to 0x0000

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - Requester i is eligible when req_valid[i]=1 and rsp_valid[i]=0.
  - If any requester is eligible, one is granted. With both eligible, the one not granted last wins. last_grant resets to 1, so requester 0 wins first.
  - req_ready[grant] is combinational, high only in IDLE. In the same cycle, the granted req_a/req_b slices are latched into eng_a/eng_b and the grant id is latched. The next state is ISSUE.
- ISSUE: eng_start=1 for exactly this cycle; the WAIT counter is cleared; the next state is WAIT.
- WAIT:
  - On eng_done=1, capture {eng_w, eng_ones, eng_valid} with timeout=0, then go to DELIVER.
  - Otherwise the counter increments. When it reaches TIMEOUT, capture w=0, ones=0, {timeout=1, valid=0}, then go to DELIVER.
  - If eng_done arrives in the same cycle the counter hits TIMEOUT, eng_done wins.
- DELIVER: write the captured data to slot [id]; set rsp_valid[id]=1; increment job_count; set last_grant=id; go to IDLE.
- rsp_ack[i] clears rsp_valid[i] on the next edge. Slot data holds its value until overwritten.
  - Ack on an empty slot has no effect.
  - A slot is never written while full, because a full slot makes its requester ineligible, so ack and write cannot collide.
- eng_done outside WAIT is ignored. Engine outputs are sampled only in WAIT.
- req_valid dropping before the handshake is legal; nothing is latched.

## Timing
- Reset (n_reset=0 at an edge): state=IDLE; req_ready=0, rsp_valid=0, rsp_w/rsp_ones/rsp_status=0, eng_start=0, eng_a/eng_b=0, busy=0, job_count=0, last_grant=1.
- Reset mid-job aborts the job with no slot write and no job_count increment. A later eng_done is ignored.
- Cycle numbering:
  - c0: handshake (req_valid & req_ready).
  - c1: ISSUE, eng_start=1.
  - c2 onward: WAIT.
  - eng_done high in cycle c2+k: DELIVER in c3+k. rsp_valid and the new job_count are visible from c4+k, and IDLE can grant again in c4+k.
- Minimum turnaround from handshake to next handshake: 4 cycles (k=0).
- Timeout with no eng_done: DELIVER in c2+TIMEOUT; rsp_valid visible from c3+TIMEOUT.
- busy is high from c1 through DELIVER inclusive.

## Test plan
- Single job, engine model answering 24 cycles after eng_start: req0 A=3, B=5 -> eng_start in c1, rsp_w0=0x0000000F, rsp_ones0=4, rsp_status0=01, job_count=1.
- Overflow: req1 A=0xFFFFFF, B=0xFFFFFF, engine returns eng_w=0x00000001, eng_valid=0, eng_ones=1 -> slot1 holds 0x00000001 / 1 / status 00; slot0 untouched.
- Contention: both req_valid held continuously, acks returned immediately -> grants alternate 0,1,0,1; 4 jobs give job_count=4.
- Full-slot blocking: req0 valid, slot0 never acked, req1 idle -> after the first job, req_ready0 stays 0. Ack slot0 -> grant on the cycle after the ack edge.
- Timeout: TIMEOUT=8, engine silent -> rsp_status=10, rsp_w=0, rsp_ones=0, rsp_valid at c11. Then eng_done in the same cycle the counter hits TIMEOUT -> normal result, timeout=0.
- Reset mid-WAIT, then a late eng_done: all outputs at reset values, no slot write, job_count=0. Also preload job_count to 0xFFFF, complete one job -> job_count=0x0000.
